vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_timing_if.sv | 32 +++
 rtl/vga_delay_line.sv | 40 ++++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe the 200x600 mode driven by the current card.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 200;
    localparam int DEF_H_FP       = 10;
    localparam int DEF_H_SYNC     = 32;
    localparam int DEF_H_BP       = 22;
    localparam int DEF_V_ACTIVE   = 600;
    localparam int DEF_V_FP       = 1;
    localparam int DEF_V_SYNC     = 4;
    localparam int DEF_V_BP       = 23;
    localparam int DEF_PIPE_DEPTH = 1;

    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    // Counter widths must never collapse to zero bits, even for a total of 1.
    function automatic int safe_clog2(input int value);
        int bits;
        bits = $clog2(value);
        return (bits < 1) ? 1 : bits;
    endfunction

    localparam int DEF_H_BITS =
        safe_clog2(DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP);
    localparam int DEF_V_BITS =
        safe_clog2(DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP);

endpackage

// File: rtl/vga_timing_if.sv
// Timing bundle between the raster generator (master) and its consumers.
// pix_en flows into the generator; everything else is produced by it.
interface vga_timing_if
    import vga_timing_pkg::*;
#(
    parameter int H_BITS = DEF_H_BITS,
    parameter int V_BITS = DEF_V_BITS
);

    logic              pix_en;
    logic [H_BITS-1:0] h_count;
    logic [V_BITS-1:0] v_count;
    logic              fetch_valid;
    logic              line_start;
    logic              frame_start;
    logic              de;
    logic              h_sync;
    logic              v_sync;

    modport master (
        input  pix_en,
        output h_count, v_count, fetch_valid, line_start, frame_start,
        output de, h_sync, v_sync
    );

    modport slave (
        output pix_en,
        input  h_count, v_count, fetch_valid, line_start, frame_start,
        input  de, h_sync, v_sync
    );

endinterface

// File: rtl/vga_delay_line.sv
// Enabled shift register with a synchronous clear to a per-bit value.
// DEPTH of zero degenerates to a wire so callers need no special case.
module vga_delay_line
    import vga_timing_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_i, en_i};
        assign q_o         = d_i;
    end else begin : g_stages
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: fetch-stage pixel/line counters plus de/sync outputs
// delayed by PIPE_DEPTH pixels to line up with frame-buffer read data.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic H_POL      = POL_LOW,
    parameter logic V_POL      = POL_LOW,
    parameter int   PIPE_DEPTH = DEF_PIPE_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_BITS  = safe_clog2(H_TOTAL);
    localparam int V_BITS  = safe_clog2(V_TOTAL);

    localparam logic [H_BITS-1:0] H_LAST     = H_BITS'(H_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_LAST     = V_BITS'(V_TOTAL - 1);
    localparam logic [H_BITS-1:0] H_VIS_END  = H_BITS'(H_ACTIVE);
    localparam logic [V_BITS-1:0] V_VIS_END  = V_BITS'(V_ACTIVE);
    localparam logic [H_BITS-1:0] H_SYNC_LO  = H_BITS'(H_ACTIVE + H_FP);
    localparam logic [H_BITS-1:0] H_SYNC_HI  = H_BITS'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_BITS-1:0] V_SYNC_LO  = V_BITS'(V_ACTIVE + V_FP);
    localparam logic [V_BITS-1:0] V_SYNC_HI  = V_BITS'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1 ||
        H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0 ||
        PIPE_DEPTH < 0 || PIPE_DEPTH > 7) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [H_BITS-1:0] h_count_q, h_count_d;
    logic [V_BITS-1:0] v_count_q, v_count_d;

    always_comb begin
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (bus.pix_en) begin
            if (h_count_q == H_LAST) begin
                h_count_d = '0;
                v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 1'b1;
            end else begin
                h_count_d = h_count_q + 1'b1;
            end
        end
    end

    // Reset parks on the final blanking pixel so the first enabled edge lands on (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            h_count_q <= H_LAST;
            v_count_q <= V_LAST;
        end else begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
        end
    end

    logic fetch_valid;
    logic hsync_raw;
    logic vsync_raw;
    logic [2:0] pipe_in;
    logic [2:0] pipe_out;

    assign fetch_valid = (h_count_q < H_VIS_END) && (v_count_q < V_VIS_END);
    assign hsync_raw   = (h_count_q >= H_SYNC_LO) && (h_count_q <= H_SYNC_HI);
    assign vsync_raw   = (v_count_q >= V_SYNC_LO) && (v_count_q <= V_SYNC_HI);

    // Polarity is applied before the delay so cleared stages sit at the idle pin level.
    assign pipe_in = {fetch_valid, hsync_raw ? H_POL : ~H_POL, vsync_raw ? V_POL : ~V_POL};

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DEPTH),
        .RST_VAL ({1'b0, ~H_POL, ~V_POL})
    ) u_delay (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (bus.pix_en),
        .d_i   (pipe_in),
        .q_o   (pipe_out)
    );

    assign bus.h_count     = h_count_q;
    assign bus.v_count     = v_count_q;
    assign bus.fetch_valid = fetch_valid;
    assign bus.line_start  = (h_count_q == '0);
    assign bus.frame_start = (h_count_q == '0) && (v_count_q == '0);
    assign bus.de          = pipe_out[2];
    assign bus.h_sync      = pipe_out[1];
    assign bus.v_sync      = pipe_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven in lock-step and
// compared every cycle against a pixel-index model of the raster.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    // Configuration 0: default mode. 1: tiny, active-high syncs, 3-deep pipe.
    // 2: tiny, no front porch / back porch, zero-depth pipe.
    localparam int C_HA   [3] = '{200, 8, 6};
    localparam int C_HFP  [3] = '{10,  2, 0};
    localparam int C_HS   [3] = '{32,  3, 2};
    localparam int C_HBP  [3] = '{22,  2, 3};
    localparam int C_VA   [3] = '{600, 5, 4};
    localparam int C_VFP  [3] = '{1,   1, 2};
    localparam int C_VS   [3] = '{4,   2, 1};
    localparam int C_VBP  [3] = '{23,  1, 0};
    localparam int C_HPOL [3] = '{0,   1, 0};
    localparam int C_VPOL [3] = '{0,   1, 0};
    localparam int C_PIPE [3] = '{1,   3, 0};

    localparam int H0_BITS = safe_clog2(264);
    localparam int V0_BITS = safe_clog2(628);
    localparam int H1_BITS = safe_clog2(15);
    localparam int V1_BITS = safe_clog2(9);
    localparam int H2_BITS = safe_clog2(11);
    localparam int V2_BITS = safe_clog2(7);

    logic clk;
    logic rst;
    logic pix_en;

    vga_timing_if #(.H_BITS(H0_BITS), .V_BITS(V0_BITS)) bus0 ();
    vga_timing_if #(.H_BITS(H1_BITS), .V_BITS(V1_BITS)) bus1 ();
    vga_timing_if #(.H_BITS(H2_BITS), .V_BITS(V2_BITS)) bus2 ();

    assign bus0.pix_en = pix_en;
    assign bus1.pix_en = pix_en;
    assign bus2.pix_en = pix_en;

    vga_timing_gen u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (5), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .H_POL (POL_HIGH), .V_POL (POL_HIGH), .PIPE_DEPTH (3)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    vga_timing_gen #(
        .H_ACTIVE (6), .H_FP (0), .H_SYNC (2), .H_BP (3),
        .V_ACTIVE (4), .V_FP (2), .V_SYNC (1), .V_BP (0),
        .H_POL (POL_LOW), .V_POL (POL_LOW), .PIPE_DEPTH (0)
    ) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The raster is a single pixel index 0..frame-1; reset parks it on the last one.
    int pos [3];
    int nen [3];
    bit model_ok = 1'b0;

    function automatic int h_tot(input int id);
        return C_HA[id] + C_HFP[id] + C_HS[id] + C_HBP[id];
    endfunction

    function automatic int frame_len(input int id);
        return h_tot(id) * (C_VA[id] + C_VFP[id] + C_VS[id] + C_VBP[id]);
    endfunction

    function automatic logic [2:0] ref_decode(input int id, input int p);
        int  h, v;
        logic fv, hr, vr;
        h  = p % h_tot(id);
        v  = p / h_tot(id);
        fv = (h < C_HA[id]) && (v < C_VA[id]);
        hr = (h >= C_HA[id] + C_HFP[id]) && (h < C_HA[id] + C_HFP[id] + C_HS[id]);
        vr = (v >= C_VA[id] + C_VFP[id]) && (v < C_VA[id] + C_VFP[id] + C_VS[id]);
        return {fv, hr ? (C_HPOL[id] != 0) : (C_HPOL[id] == 0),
                    vr ? (C_VPOL[id] != 0) : (C_VPOL[id] == 0)};
    endfunction

    // Outputs show the raster PIPE pixels back, or idle levels until that many edges occur.
    function automatic logic [2:0] ref_out(input int id, input int p, input int n);
        if (n < C_PIPE[id]) return {1'b0, C_HPOL[id] == 0, C_VPOL[id] == 0};
        return ref_decode(id, (p - C_PIPE[id] + frame_len(id)) % frame_len(id));
    endfunction

    always @(posedge clk) begin
        for (int id = 0; id < 3; id++) begin
            if (rst) begin
                pos[id] <= frame_len(id) - 1;
                nen[id] <= 0;
            end else if (pix_en) begin
                pos[id] <= (pos[id] + 1) % frame_len(id);
                nen[id] <= (nen[id] < 8) ? nen[id] + 1 : 8;
            end
        end
        if (rst) model_ok <= 1'b1;
    end

    // ---------------- per-cycle monitor and pulse measurements ----------------
    int epoch     = 0;
    int en_period = 0;

    logic [31:0] o_h, o_v, o_fv, o_ls, o_fs, o_de, o_hs, o_vs;
    logic [2:0]  e_out, e_cur;
    int          e_h, e_v;

    logic prev_hs0 = 1'b1, prev_ls0 = 1'b0, prev_fs1 = 1'b0, prev_fs2 = 1'b0;
    int   hs0_run = 0, hs0_ep = -1;
    int   ls0_run = 0, ls0_ep = -1;
    int   fs1_gap = 0, fs1_ep = -1;
    int   de2_cnt = 0, fs2_ep = -1;

    always @(negedge clk) begin
        if (model_ok) begin
            for (int id = 0; id < 3; id++) begin
                e_out = ref_out(id, pos[id], nen[id]);
                e_cur = ref_decode(id, pos[id]);
                e_h   = pos[id] % h_tot(id);
                e_v   = pos[id] / h_tot(id);
                case (id)
                    0: begin
                        o_h = 32'(bus0.h_count); o_v = 32'(bus0.v_count);
                        o_fv = 32'(bus0.fetch_valid); o_ls = 32'(bus0.line_start);
                        o_fs = 32'(bus0.frame_start); o_de = 32'(bus0.de);
                        o_hs = 32'(bus0.h_sync); o_vs = 32'(bus0.v_sync);
                    end
                    1: begin
                        o_h = 32'(bus1.h_count); o_v = 32'(bus1.v_count);
                        o_fv = 32'(bus1.fetch_valid); o_ls = 32'(bus1.line_start);
                        o_fs = 32'(bus1.frame_start); o_de = 32'(bus1.de);
                        o_hs = 32'(bus1.h_sync); o_vs = 32'(bus1.v_sync);
                    end
                    default: begin
                        o_h = 32'(bus2.h_count); o_v = 32'(bus2.v_count);
                        o_fv = 32'(bus2.fetch_valid); o_ls = 32'(bus2.line_start);
                        o_fs = 32'(bus2.frame_start); o_de = 32'(bus2.de);
                        o_hs = 32'(bus2.h_sync); o_vs = 32'(bus2.v_sync);
                    end
                endcase
                check($sformatf("d%0d.h_count", id), o_h, 32'(e_h));
                check($sformatf("d%0d.v_count", id), o_v, 32'(e_v));
                check($sformatf("d%0d.fetch_valid", id), o_fv, 32'(e_cur[2]));
                check($sformatf("d%0d.line_start", id), o_ls, 32'(e_h == 0));
                check($sformatf("d%0d.frame_start", id), o_fs, 32'(e_h == 0 && e_v == 0));
                check($sformatf("d%0d.de", id), o_de, 32'(e_out[2]));
                check($sformatf("d%0d.h_sync", id), o_hs, 32'(e_out[1]));
                check($sformatf("d%0d.v_sync", id), o_vs, 32'(e_out[0]));
            end

            // Pulse widths in clk cycles scale with the enable period.
            if (!bus0.h_sync) begin
                if (prev_hs0) begin hs0_run = 1; hs0_ep = epoch; end
                else hs0_run++;
            end else if (!prev_hs0 && hs0_ep == epoch && en_period != 0) begin
                check("d0.hsync_width", 32'(hs0_run), 32'(32 * en_period));
            end
            prev_hs0 = bus0.h_sync;

            if (bus0.line_start) begin
                if (!prev_ls0) begin ls0_run = 1; ls0_ep = epoch; end
                else ls0_run++;
            end else if (prev_ls0 && ls0_ep == epoch && en_period != 0) begin
                check("d0.line_start_width", 32'(ls0_run), 32'(en_period));
            end
            prev_ls0 = bus0.line_start;

            if (bus1.frame_start && !prev_fs1) begin
                if (fs1_ep == epoch && en_period != 0)
                    check("d1.frame_period", 32'(fs1_gap), 32'(frame_len(1) * en_period));
                fs1_gap = 0;
                fs1_ep  = epoch;
            end
            fs1_gap++;
            prev_fs1 = bus1.frame_start;

            if (bus2.frame_start && !prev_fs2) begin
                if (fs2_ep == epoch && en_period != 0)
                    check("d2.de_per_frame", 32'(de2_cnt), 32'(C_HA[2] * C_VA[2] * en_period));
                de2_cnt = 0;
                fs2_ep  = epoch;
            end
            if (bus2.de) de2_cnt++;
            prev_fs2 = bus2.frame_start;
        end
    end

    // ---------------- driver tasks ----------------
    // mode 0: pix_en every cycle, 1: one cycle in four, 2: random with rare resets.
    task automatic run_phase(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = 1'b0;
            case (mode)
                0:       pix_en = 1'b1;
                1:       pix_en = (i % 4 == 0);
                default: begin
                    pix_en = 1'($urandom_range(0, 1));
                    rst    = ($urandom_range(0, 149) == 0);
                end
            endcase
            if (i == 0) begin
                #1;
                epoch++;
                en_period = (mode == 0) ? 1 : (mode == 1) ? 4 : 0;
            end
        end
    endtask

    task automatic reset_mid_vsync();
        bit found;
        found = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        pix_en = 1'b1;
        #1;
        epoch++;
        en_period = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (bus1.v_count == 4'(6) && bus1.h_count == 4'(4)) found = 1'b1;
        end
        check("d1.reached_vsync", 32'(found), 32'd1);
        if (found) begin
            check("d1.v_sync_before_rst", 32'(bus1.v_sync), 32'd1);
            rst = 1'b1;
            @(negedge clk);
            check("d1.v_sync_after_rst", 32'(bus1.v_sync), 32'd0);
            check("d1.h_sync_after_rst", 32'(bus1.h_sync), 32'd0);
            rst = 1'b0;
            @(negedge clk);
            check("d1.h_after_release", 32'(bus1.h_count), 32'd0);
            check("d1.v_after_release", 32'(bus1.v_count), 32'd0);
            check("d1.fs_after_release", 32'(bus1.frame_start), 32'd1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
        check("d0.rst_h_count", 32'(bus0.h_count), 32'd263);
        check("d0.rst_v_count", 32'(bus0.v_count), 32'd627);
        check("d0.rst_fetch_valid", 32'(bus0.fetch_valid), 32'd0);
        check("d0.rst_frame_start", 32'(bus0.frame_start), 32'd0);
        check("d0.rst_de", 32'(bus0.de), 32'd0);
        check("d0.rst_h_sync", 32'(bus0.h_sync), 32'd1);
        check("d0.rst_v_sync", 32'(bus0.v_sync), 32'd1);
        check("d1.rst_h_sync", 32'(bus1.h_sync), 32'd0);
        check("d1.rst_v_sync", 32'(bus1.v_sync), 32'd0);

        @(negedge clk);
        rst    = 1'b0;
        pix_en = 1'b1;
        @(negedge clk);
        check("d0.first_h", 32'(bus0.h_count), 32'd0);
        check("d0.first_v", 32'(bus0.v_count), 32'd0);
        check("d0.first_frame_start", 32'(bus0.frame_start), 32'd1);

        run_phase(700, 0);
        run_phase(1300, 1);
        run_phase(1500, 2);
        reset_mid_vsync();
        run_phase(400, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
